// File: rtl/rtmq_output_sr_pkg.sv
// Shared peripheral constants: register/ALU bus widths, ALU bus layout,
// status-word field offsets and the clog2 helper.
package rtmq_output_sr_pkg;

    localparam int unsigned W_REG = 32;
    localparam int unsigned W_ADR = 8;
    localparam int unsigned W_ALU = W_REG + W_ADR + 3;

    // ALU output bus: {imm, ren, wen, adr, dat}, data in the low word
    typedef struct packed {
        logic             imm;
        logic             ren;
        logic             wen;
        logic [W_ADR-1:0] adr;
        logic [W_REG-1:0] dat;
    } alu_bus_t;

    // Status bits sit directly above the right-aligned counter field
    localparam int unsigned OSR_VLD_OFS = 0;
    localparam int unsigned OSR_OVF_OFS = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rtmq_acs_flg.sv
// Access-flag decoder: turns the ALU output bus into read, write and
// immediate-write strobes for one register address.
module rtmq_acs_flg
    import rtmq_output_sr_pkg::*;
#(
    parameter int unsigned ADDR = 0
) (
    input  logic [W_ALU-1:0] alu_out,
    output logic             rd,
    output logic             wr,
    output logic             imw,
    output logic [W_REG-1:0] imm_dat
);

    alu_bus_t bus;
    logic     hit;

    assign bus     = alu_bus_t'(alu_out);
    assign hit     = (bus.adr == W_ADR'(ADDR));
    assign rd      = bus.ren & hit;
    assign wr      = bus.wen & ~bus.imm & hit;
    assign imw     = bus.wen & bus.imm & hit;
    assign imm_dat = bus.dat;

endmodule

// File: rtl/rtmq_output_sr.sv
// Output shift register: assembles N_SRL register writes into one frame with
// a valid/ready handoff. Define RTMQ_OSR_OVF_EN for drop-on-overflow + sticky ovf.
module rtmq_output_sr
    import rtmq_output_sr_pkg::*;
#(
    parameter int unsigned ADDR  = 0,
    parameter int unsigned N_SRL = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W_ALU-1:0]         alu_out,
    output logic [W_REG-1:0]         reg_osr,
    output logic [W_REG*N_SRL-1:0]   dat_out,
    output logic                     dat_vld,
    input  logic                     dat_rdy
);

    localparam int unsigned W_OSR = W_REG * N_SRL;
    localparam int unsigned W_CNT = clog2(N_SRL + 1);

    logic             rd;
    logic             wr;
    logic             imw_unused;
    logic [W_REG-1:0] imm_dat_unused;

    rtmq_acs_flg #(.ADDR(ADDR)) u_acs (
        .alu_out (alu_out),
        .rd      (rd),
        .wr      (wr),
        .imw     (imw_unused),
        .imm_dat (imm_dat_unused)
    );

    logic [W_REG-1:0] wdata;
    logic [W_OSR-1:0] sr_buf;
    logic [W_OSR-1:0] buf_nxt;
    logic [W_CNT-1:0] cnt;
    logic             ovf;
    logic             frm_done;
    logic             hs;
    logic             load;

    assign wdata    = alu_out[W_REG-1:0];
    assign buf_nxt  = {wdata, sr_buf[W_OSR-1:W_REG]};
    assign frm_done = wr && (cnt == W_CNT'(N_SRL - 1));
    assign hs       = dat_vld && dat_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_buf <= '0;
            cnt    <= '0;
        end else if (wr) begin
            sr_buf <= buf_nxt;
            cnt    <= frm_done ? '0 : cnt + 1'b1;
        end
    end

`ifdef RTMQ_OSR_OVF_EN
    logic ovf_hit;

    // A pending, unaccepted frame is kept; the new one is dropped
    assign ovf_hit = frm_done && dat_vld && !dat_rdy;
    assign load    = frm_done && !ovf_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_hit) begin
            ovf <= 1'b1;
        end else if (rd) begin
            ovf <= 1'b0;
        end
    end
`else
    logic rd_unused;

    assign rd_unused = rd;
    assign load      = frm_done;
    assign ovf       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_out <= '0;
            dat_vld <= 1'b0;
        end else if (load) begin
            dat_out <= buf_nxt;
            dat_vld <= 1'b1;
        end else if (hs) begin
            dat_vld <= 1'b0;
        end
    end

    always_comb begin
        reg_osr                        = '0;
        reg_osr[W_CNT-1:0]             = cnt;
        reg_osr[W_CNT + OSR_VLD_OFS]   = dat_vld;
        reg_osr[W_CNT + OSR_OVF_OFS]   = ovf;
    end

endmodule

// File: tb/tb_rtmq_output_sr.sv
// Self-checking bench for rtmq_output_sr (N_SRL=6): vector table, directed
// corner sequences and randomized traffic against a queue-based frame model.
module tb_rtmq_output_sr;
    import rtmq_output_sr_pkg::*;

    localparam int unsigned N     = 6;
    localparam int unsigned A     = 5;
    localparam int unsigned W_OSR = W_REG * N;
    localparam int unsigned CW    = $clog2(N + 1);
`ifdef RTMQ_OSR_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [W_ALU-1:0] alu_out = '0;
    logic [W_REG-1:0] reg_osr;
    logic [W_OSR-1:0] dat_out;
    logic             dat_vld;
    logic             dat_rdy = 1'b0;

    int checks = 0;
    int failures = 0;

    rtmq_output_sr #(.ADDR(A), .N_SRL(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_out (alu_out),
        .reg_osr (reg_osr),
        .dat_out (dat_out),
        .dat_vld (dat_vld),
        .dat_rdy (dat_rdy)
    );

    always #5 clk = ~clk;

    // Reference model: words collected so far, delivered frame, flags
    logic [W_REG-1:0] m_words[$];
    logic [W_OSR-1:0] m_out = '0;
    bit               m_vld = 1'b0;
    bit               m_ovf = 1'b0;

    function automatic logic [W_ALU-1:0] mk_alu(input bit wen, input bit ren, input bit imm,
                                                 input logic [7:0] adr, input logic [31:0] d);
        alu_bus_t b;
        b.imm = imm;
        b.ren = ren;
        b.wen = wen;
        b.adr = adr;
        b.dat = d;
        return b;
    endfunction

    function automatic logic [W_REG-1:0] exp_osr();
        logic [W_REG-1:0] r;
        r = W_REG'(m_words.size());
        r[CW]   = m_vld;
        r[CW+1] = m_ovf;
        return r;
    endfunction

    function automatic logic [W_OSR-1:0] frame_of(input int unsigned base);
        logic [W_OSR-1:0] f;
        for (int unsigned i = 0; i < N; i++) f[i*W_REG +: W_REG] = W_REG'(base + i);
        return f;
    endfunction

    task automatic check(input string name, input logic [W_OSR-1:0] act, input logic [W_OSR-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " dat_out"}, dat_out, m_out);
        check({tag, " dat_vld"}, W_OSR'(dat_vld), W_OSR'(m_vld));
        check({tag, " reg_osr"}, W_OSR'(reg_osr), W_OSR'(exp_osr()));
    endtask

    task automatic step(input bit wen, input bit ren, input bit imm, input logic [7:0] adr,
                        input logic [31:0] d, input bit rdy, input string tag);
        bit               wr_hit;
        bit               rd_hit;
        bit               hs;
        bit               done;
        logic [W_OSR-1:0] frame;
        alu_out = mk_alu(wen, ren, imm, adr, d);
        dat_rdy = rdy;
        wr_hit  = wen && !imm && (adr == 8'(A));
        rd_hit  = ren && (adr == 8'(A));
        hs      = m_vld && rdy;
        done    = 1'b0;
        if (wr_hit) begin
            m_words.push_back(d);
            if (m_words.size() == N) begin
                for (int unsigned i = 0; i < N; i++) frame[i*W_REG +: W_REG] = m_words[i];
                m_words.delete();
                done = 1'b1;
                if (m_vld && !rdy) begin
                    if (OVF_EN) m_ovf = 1'b1;
                    else        m_out = frame;
                end else begin
                    m_out = frame;
                    m_vld = 1'b1;
                    if (rd_hit) m_ovf = 1'b0;
                end
            end
        end
        if (!done && hs) m_vld = 1'b0;
        if (!done && rd_hit) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        alu_out = '0;
        check_model(tag);
    endtask

    task automatic wr(input logic [31:0] d, input bit rdy, input string tag);
        step(1'b1, 1'b0, 1'b0, 8'(A), d, rdy, tag);
    endtask

    task automatic idle(input bit rdy, input string tag);
        step(1'b0, 1'b0, 1'b0, 8'(A), 32'h0, rdy, tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, " async dat_vld"}, W_OSR'(dat_vld), '0);
        check({tag, " async dat_out"}, dat_out, '0);
        check({tag, " async reg_osr"}, W_OSR'(reg_osr), '0);
        m_words.delete();
        m_out = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_model({tag, " post"});
    endtask

    typedef struct {
        bit          wen;
        bit          ren;
        logic [31:0] d;
        bit          rdy;
        bit          e_vld;
        int unsigned e_cnt;
    } vec_t;

    vec_t             tbl[$];
    logic [W_OSR-1:0] fa;
    logic [W_OSR-1:0] fb;

    initial begin
        // write 1..6 with consumer ready, then one idle cycle to consume
        for (int unsigned i = 1; i <= N; i++)
            tbl.push_back('{wen: 1'b1, ren: 1'b0, d: 32'(i), rdy: 1'b1,
                            e_vld: (i == N), e_cnt: (i == N) ? 0 : i});
        tbl.push_back('{wen: 1'b0, ren: 1'b0, d: 32'h0, rdy: 1'b1, e_vld: 1'b0, e_cnt: 0});

        #2;
        do_reset("reset");

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wen, tbl[i].ren, 1'b0, 8'(A), tbl[i].d, tbl[i].rdy, "tbl");
            check("tbl vld", W_OSR'(dat_vld), W_OSR'(tbl[i].e_vld));
            check("tbl cnt", W_OSR'(reg_osr[CW-1:0]), W_OSR'(tbl[i].e_cnt));
            if (i == N - 1) check("tbl frame 1..6", dat_out, frame_of(1));
        end
        check("tbl frame held", dat_out, frame_of(1));

        // five words then a status read
        for (int unsigned i = 0; i < 5; i++) wr(32'h10 + i, 1'b1, "part");
        step(1'b0, 1'b1, 1'b0, 8'(A), 32'h0, 1'b1, "part rd");
        check("part status", W_OSR'(reg_osr), W_OSR'(32'h5));
        wr(32'h15, 1'b1, "part last");
        idle(1'b1, "part drain");

        // two frames with consumer stalled
        fa = frame_of(32'hA0);
        fb = frame_of(32'hB0);
        for (int unsigned i = 0; i < N; i++) wr(32'hA0 + i, 1'b0, "ovf A");
        for (int unsigned i = 0; i < N; i++) wr(32'hB0 + i, 1'b0, "ovf B");
        check("ovf dat_out", dat_out, OVF_EN ? fa : fb);
        check("ovf status", W_OSR'(reg_osr), OVF_EN ? W_OSR'(32'h18) : W_OSR'(32'h08));
        for (int unsigned i = 0; i < 100; i++) begin
            idle(1'b0, "hold");
            check("hold dat_out", dat_out, OVF_EN ? fa : fb);
            check("hold dat_vld", W_OSR'(dat_vld), W_OSR'(1));
        end
        step(1'b0, 1'b1, 1'b0, 8'(A), 32'h0, 1'b0, "ovf rd");
        check("ovf cleared", W_OSR'(reg_osr), W_OSR'(32'h08));

        // completion coinciding with handshake of the pending frame
        for (int unsigned i = 0; i < N - 1; i++) wr(32'hC0 + i, 1'b0, "coin");
        wr(32'hC5, 1'b1, "coin last");
        check("coin dat_out", dat_out, frame_of(32'hC0));
        check("coin status", W_OSR'(reg_osr), W_OSR'(32'h08));
        idle(1'b1, "coin drain");
        check("coin drained", W_OSR'(dat_vld), W_OSR'(0));

        // reset mid-frame, then a clean frame
        for (int unsigned i = 0; i < 3; i++) wr(32'hEE0 + i, 1'b1, "mid");
        do_reset("mid reset");
        for (int unsigned i = 1; i <= N; i++) wr(32'(i), 1'b1, "fresh");
        check("fresh frame", dat_out, frame_of(1));
        idle(1'b1, "fresh drain");

        // randomized traffic, including foreign addresses and immediate writes
        for (int unsigned i = 0; i < 600; i++) begin
            step(1'b1 && ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'(A),
                 32'($urandom), ($urandom_range(0, 9) < 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtmq_output_sr.md
RTMQ_OUTPUT_SR -- requirements
Module: rtmq_output_sr

Interface
REQ-001 SHALL have parameter ADDR, default 0, meaning the register address decoded from the ALU bus.
REQ-002 SHALL have parameter N_SRL, default 6, meaning the frame length in words (N_SRL >= 2).
REQ-003 SHALL take W_REG and W_ALU from the shared peripheral constants, and SHALL define W_OSR = W_REG*N_SRL.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port alu_out, input, W_ALU bits: the ALU output bus carrying write strobes and write data.
REQ-007 SHALL have port reg_osr, output, W_REG bits: status word returned to the regfile.
REQ-008 SHALL have port dat_out, output, W_OSR bits: the assembled frame; word 0 sits in bits [W_REG-1:0].
REQ-009 SHALL have port dat_vld, output, 1 bit: dat_out holds an unconsumed frame.
REQ-010 SHALL have port dat_rdy, input, 1 bit: the consumer accepts the frame when dat_vld and dat_rdy are both high.

Function
REQ-011 SHALL decode read and write strobes for ADDR through the shared access-flag decoder; write data is alu_out[W_REG-1:0].
REQ-012 Each write SHALL shift the assembly buffer right by W_REG and place the data in the top word: buf <= {wdata, buf[W_OSR-1:W_REG]}.
REQ-013 Each write SHALL increment word counter cnt, of width clog2(N_SRL+1).
REQ-014 On the write that makes cnt reach N_SRL (frame complete), the next cycle SHALL see:
  - the shifted buffer copied to dat_out;
  - dat_vld set to 1;
  - cnt cleared to 0.
REQ-015 dat_out SHALL be stable while dat_vld=1; the handshake SHALL clear dat_vld one cycle after dat_vld&dat_rdy.
REQ-016 Frame completion coinciding with a handshake SHALL load the new frame and hold dat_vld=1, with no overflow.
REQ-017 Frame completion while dat_vld=1 and dat_rdy=0 is an overflow, handled per REQ-023 and REQ-024.
REQ-018 reg_osr SHALL read {ovf, dat_vld, cnt} right-aligned, zero-extended to W_REG bits.
REQ-019 A read strobe for ADDR SHALL clear ovf on the next cycle; an overflow in the same cycle SHALL win and leave ovf=1.
REQ-020 Writes SHALL always be accepted; the block never stalls the core.

Reset
REQ-021 rst_n low SHALL immediately force buf=0, cnt=0, dat_out=0, dat_vld=0, ovf=0, at any point including mid-frame.
REQ-022 After rst_n deasserts, the first write SHALL be treated as word 0 of a new frame.

Configuration
REQ-023 With RTMQ_OSR_OVF_EN defined, an overflow SHALL:
  - discard the new frame;
  - keep dat_out unchanged;
  - set sticky ovf to 1.
REQ-024 Without RTMQ_OSR_OVF_EN, an overflow SHALL overwrite dat_out with the new frame, keep dat_vld=1, and tie ovf to 0.

Structure
REQ-025 W_REG, W_ALU, the status-field bit positions and the clog2 helper SHALL live in the shared peripheral package; W_OSR and the cnt width are local.
REQ-026 The only sub-module SHALL be the shared access-flag decoder rtmq_acs_flg, with its immediate-write outputs unused.

Verification (N_SRL=6, W_REG=32)
REQ-027 Write 1..6 with dat_rdy=1 -> dat_out = {6,5,4,3,2,1}, dat_vld pulses 1 cycle, cnt returns to 0.
REQ-028 Write 5 words, read reg_osr -> cnt field = 5, dat_vld = 0, ovf = 0.
REQ-029 dat_rdy=0, send two frames A and B:
  - with OVF_EN -> dat_out = A, ovf = 1, and a subsequent read clears ovf;
  - without OVF_EN -> dat_out = B.
REQ-030 dat_rdy rises in the same cycle as the 6th write of frame B while A is pending -> A is consumed, dat_out = B, dat_vld stays 1, ovf = 0.
REQ-031 Assert rst_n=0 after 3 writes, release, write 1..6 -> dat_out = {6,5,4,3,2,1} with no stale words.
REQ-032 Hold dat_rdy=0 for 100 cycles with a frame pending -> dat_out and dat_vld remain constant.
